wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: three result sources (ALU, FPU, MEM) share one register-file write port.
// Define WB_RR_EN for round-robin grant; otherwise fixed priority MEM > ALU > FPU.
module wb_arbiter (
    input  logic        clk,
    input  logic        rstn,
    input  logic [2:0]  src_valid,
    output logic [2:0]  src_ready,
    input  logic [2:0]  src_fp,
    input  logic [14:0] src_addr,
    input  logic [95:0] src_data,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic        gp_we,
    output logic        fp_we,
    output logic        idle
);

    // Returns {found, index} of the first full slot in the order a, b, c.
    function automatic logic [2:0] pick3(input logic [2:0] full,
                                         input logic [1:0] a,
                                         input logic [1:0] b,
                                         input logic [1:0] c);
        logic [2:0] res;
        if (full[a]) begin
            res = {1'b1, a};
        end else if (full[b]) begin
            res = {1'b1, b};
        end else if (full[c]) begin
            res = {1'b1, c};
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    logic [2:0]        full_q, full_d;
    logic [2:0]        slot_fp_q, slot_fp_d;
    logic [2:0][4:0]   slot_addr_q, slot_addr_d;
    logic [2:0][31:0]  slot_data_q, slot_data_d;
    logic [4:0]        w_addr_q, w_addr_d;
    logic [31:0]       w_data_q, w_data_d;
    logic              gp_we_q, gp_we_d;
    logic              fp_we_q, fp_we_d;
    logic [2:0]        pick_s;
    logic              gnt_vld_s;
    logic [1:0]        gnt_idx_s;
    logic [2:0]        gnt_s;
    logic [2:0]        accept_s;
    logic              sel_fp_s;
    logic [4:0]        sel_addr_s;
    logic [31:0]       sel_data_s;

`ifdef WB_RR_EN
    logic [1:0]        ptr_q, ptr_d;

    // Grant search order rotates with the pointer.
    always_comb begin
        pick_s = 3'b000;
        case (ptr_q)
            2'd0:    pick_s = pick3(full_q, 2'd0, 2'd1, 2'd2);
            2'd1:    pick_s = pick3(full_q, 2'd1, 2'd2, 2'd0);
            2'd2:    pick_s = pick3(full_q, 2'd2, 2'd0, 2'd1);
            default: pick_s = pick3(full_q, 2'd0, 2'd1, 2'd2);
        endcase
    end

    // Pointer advances past the source just granted.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld_s) begin
            ptr_d = (gnt_idx_s == 2'd2) ? 2'd0 : gnt_idx_s + 2'd1;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: memory results drain first so loads never back up.
    always_comb begin
        pick_s = pick3(full_q, 2'd2, 2'd0, 2'd1);
    end
`endif

    assign gnt_vld_s = pick_s[2];
    assign gnt_idx_s = pick_s[1:0];

    // One-hot grant, ready and handshake per source.
    always_comb begin
        gnt_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            gnt_s[i] = gnt_vld_s && (gnt_idx_s == 2'(i));
        end
        src_ready = ~full_q | gnt_s;
        accept_s  = src_valid & src_ready;
    end

    // Slot update: a refill wins over the clear caused by a grant.
    always_comb begin
        full_d      = full_q;
        slot_fp_d   = slot_fp_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        for (int i = 0; i < 3; i++) begin
            if (accept_s[i]) begin
                full_d[i]      = 1'b1;
                slot_fp_d[i]   = src_fp[i];
                slot_addr_d[i] = src_addr[5*i +: 5];
                slot_data_d[i] = src_data[32*i +: 32];
            end else if (gnt_s[i]) begin
                full_d[i] = 1'b0;
            end else begin
                full_d[i] = full_q[i];
            end
        end
    end

    // Granted-entry mux.
    always_comb begin
        sel_fp_s   = 1'b0;
        sel_addr_s = 5'd0;
        sel_data_s = 32'd0;
        case (gnt_idx_s)
            2'd0:    begin sel_fp_s = slot_fp_q[0]; sel_addr_s = slot_addr_q[0]; sel_data_s = slot_data_q[0]; end
            2'd1:    begin sel_fp_s = slot_fp_q[1]; sel_addr_s = slot_addr_q[1]; sel_data_s = slot_data_q[1]; end
            2'd2:    begin sel_fp_s = slot_fp_q[2]; sel_addr_s = slot_addr_q[2]; sel_data_s = slot_data_q[2]; end
            default: begin sel_fp_s = 1'b0; sel_addr_s = 5'd0; sel_data_s = 32'd0; end
        endcase
    end

    // Write port next state; gp r0 writes are consumed silently.
    always_comb begin
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        gp_we_d  = 1'b0;
        fp_we_d  = 1'b0;
        if (gnt_vld_s) begin
            w_addr_d = sel_addr_s;
            w_data_d = sel_data_s;
            fp_we_d  = sel_fp_s;
            gp_we_d  = !sel_fp_s && (sel_addr_s != 5'd0);
        end else begin
            gp_we_d = 1'b0;
            fp_we_d = 1'b0;
        end
    end

    // Slot and write-port registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_q      <= 3'b000;
            slot_fp_q   <= 3'b000;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            w_addr_q    <= 5'd0;
            w_data_q    <= 32'd0;
            gp_we_q     <= 1'b0;
            fp_we_q     <= 1'b0;
        end else begin
            full_q      <= full_d;
            slot_fp_q   <= slot_fp_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            gp_we_q     <= gp_we_d;
            fp_we_q     <= fp_we_d;
        end
    end

    assign w_addr = w_addr_q;
    assign w_data = w_data_q;
    assign gp_we  = gp_we_q;
    assign fp_we  = fp_we_q;
    assign idle   = (full_q == 3'b000) && !gp_we_q && !fp_we_q;

endmodule
